mole_spawner: RTL
=================

// Module: mole_spawner
// PURPOSE
//  Upstream stage of the whack-a-mole scorer: drives ledr[17:0] (one-hot mole) consumed by the
//  switch/mole hit detector, and takes back that stage's registered hit pulse (point_1).
//  Pseudo-random position, timed up/gap windows, early clear on hit, miss pulse on expiry,
//  up-window shrinks with each hit.
// PARAMETERS
//  N_LEDS      18          number of mole positions (2..32)
//  UP_CYCLES   25_000_000  initial mole up-time, clk cycles
//  MIN_UP      5_000_000   floor for up-time after speed-ups
//  UP_STEP     1_000_000   up-time reduction per hit
//  GAP_CYCLES  12_500_000  dark time between moles
//  LFSR_SEED   16'hACE1    reset value of LFSR, must be non-zero
// PORTS
//  clk       in   1       system clock; single clock domain
//  rst       in   1       asynchronous, active-high reset
//  enable    in   1       game running; low forces IDLE
//  hit       in   1       registered hit pulse (point_1) from hit detector
//  ledr      out  N_LEDS  one-hot mole display, all-zero when no mole
//  mole_idx  out  5       index of current/last mole
//  mole_up   out  1       high while a mole is lit (== |ledr)
//  spawn     out  1       1-cycle pulse, cycle ledr becomes non-zero
//  miss      out  1       1-cycle pulse, mole expired without hit
// BEHAVIOUR
//  Reset: state=IDLE, ledr=0, mole_idx=0, mole_up=0, spawn=0, miss=0, up_len=UP_CYCLES,
//   prev_idx=N_LEDS-1, lfsr=LFSR_SEED. All outputs registered.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every clk in every state (incl. IDLE).
//  States IDLE -> GAP -> UP -> GAP ...
//   IDLE: ledr=0. enable=1 -> GAP, gap_cnt=GAP_CYCLES-1, up_len=UP_CYCLES.
//   GAP: ledr=0; gap_cnt decrements; at gap_cnt==0 -> UP next edge.
//   GAP->UP edge: r=lfsr[4:0]; idx = (r>=N_LEDS)? r-N_LEDS : r; if idx>=N_LEDS, idx=idx-N_LEDS;
//    if idx==prev_idx, idx=(idx==N_LEDS-1)?0:idx+1. Register ledr=1<<idx, mole_idx=idx,
//    prev_idx=idx, spawn=1, up_cnt=up_len-1.
//   UP: up_cnt decrements.
//    hit=1 -> GAP next edge, ledr=0, gap_cnt=GAP_CYCLES-1, up_len=max(up_len-UP_STEP, MIN_UP).
//    up_cnt==0 && !hit -> GAP next edge, ledr=0, miss=1 for that cycle, up_len unchanged.
//    hit and up_cnt==0 same cycle: hit wins, no miss, up_len decremented.
//  Mole lit exactly up_len cycles when unhit; dark exactly GAP_CYCLES cycles between moles.
//  hit in IDLE or GAP ignored (late pulses from detector's 2-cycle latency: no effect).
//  enable=0 in any state -> IDLE next edge, ledr=0, no miss/spawn; mid-UP abort is not a miss.
//  enable re-assert restarts from GAP with up_len=UP_CYCLES (lfsr/prev_idx not reset).
//  Async rst mid-UP: ledr clears immediately on assertion (no clock needed).
//  Counters width $clog2(max(UP_CYCLES,GAP_CYCLES)+1); up_len subtraction saturating, no wrap.
// STRUCTURE
//  mole_pkg: state enum {IDLE,GAP,UP}, LFSR_TAPS, N_LEDS_DEFAULT, index-reduction function.
//  Sub-module lfsr16 (clk, rst, seed param, q[15:0]) free-running; rest in one FSM+counter file.
// TESTING (bench params: UP_CYCLES=8, MIN_UP=4, UP_STEP=2, GAP_CYCLES=4)
//  1 rst high, enable=0, 20 clk -> ledr=0, spawn=miss=0; assert rst mid-UP -> ledr=0 same cycle.
//  2 enable=1, no hit -> spawn 4 cycles after enable, ledr one-hot 8 cycles, miss pulse on the
//    clear cycle, next spawn 4 cycles later; consecutive mole_idx never equal, all <18.
//  3 hit on 3rd UP cycle of each mole, 4 moles -> up-time budgets 8,6,4,4 observed (floor), no miss.
//  4 hit coincident with last UP cycle -> ledr clears, miss stays 0, up_len reduced by 2.
//  5 enable dropped mid-UP -> ledr=0 next edge, no miss; re-enable -> up-time back to 8.
//  6 hit pulses during GAP/IDLE -> no state change, up_len unchanged; 1000 spawns -> every
//    index 0..17 seen at least once.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared types and helpers for the whack-a-mole spawner: FSM states, LFSR taps,
// and the reduction of a raw 5-bit random value to a legal, non-repeating mole index.
package mole_pkg;

  typedef enum logic [1:0] {IDLE, GAP, UP} state_e;

  // Fibonacci taps 16,14,13,11 expressed as a mask over q[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned N_LEDS_DEFAULT = 18;

  function automatic logic [4:0] reduce_idx(input logic [4:0] r, input logic [4:0] prev,
                                            input int unsigned n);
    logic [5:0] t;
    t = {1'b0, r};
    if (t >= 6'(n)) t = t - 6'(n);
    if (t >= 6'(n)) t = t - 6'(n);
    // never light the same hole twice in a row
    if (t[4:0] == prev) t = (t == 6'(n - 1)) ? 6'd0 : t + 6'd1;
    return t[4:0];
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; advances every clock regardless of game state.
module lfsr16
  import mole_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= SEED;
    else     q_q <= {q_q[14:0], ^(q_q & LFSR_TAPS)};
  end

  assign q = q_q;

endmodule

// File: rtl/mole_spawner.sv
// Mole spawner: lights one random LED for a shrinking up-window, clears early on hit,
// pulses miss on expiry, and keeps a fixed dark gap between moles.
module mole_spawner
  import mole_pkg::*;
#(
  parameter int unsigned N_LEDS     = N_LEDS_DEFAULT,
  parameter int unsigned UP_CYCLES  = 25_000_000,
  parameter int unsigned MIN_UP     = 5_000_000,
  parameter int unsigned UP_STEP    = 1_000_000,
  parameter int unsigned GAP_CYCLES = 12_500_000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              hit,
  output logic [N_LEDS-1:0] ledr,
  output logic [4:0]        mole_idx,
  output logic              mole_up,
  output logic              spawn,
  output logic              miss
);

  localparam int unsigned CNT_MAX = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] UP_INIT  = CW'(UP_CYCLES);
  localparam logic [CW-1:0] MIN_C    = CW'(MIN_UP);
  localparam logic [CW-1:0] STEP_C   = CW'(UP_STEP);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  state_e            state_q, state_d;
  logic [CW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [CW-1:0]     up_cnt_q, up_cnt_d;
  logic [CW-1:0]     up_len_q, up_len_d;
  logic [4:0]        prev_idx_q, prev_idx_d;
  logic [N_LEDS-1:0] ledr_q, ledr_d;
  logic [4:0]        mole_idx_q, mole_idx_d;
  logic              mole_up_q, mole_up_d;
  logic              spawn_q, spawn_d;
  logic              miss_q, miss_d;

  logic [15:0]       lfsr_q;
  logic              unused_lfsr;
  logic [4:0]        new_idx;
  logic [CW-1:0]     shrunk_len;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[15:5];

  // Saturating speed-up: never wraps below zero, never drops under the floor
  always_comb begin
    shrunk_len = (up_len_q > STEP_C) ? up_len_q - STEP_C : '0;
    if (shrunk_len < MIN_C) shrunk_len = MIN_C;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gap_cnt_q  <= '0;
      up_cnt_q   <= '0;
      up_len_q   <= UP_INIT;
      prev_idx_q <= 5'(N_LEDS - 1);
      ledr_q     <= '0;
      mole_idx_q <= '0;
      mole_up_q  <= 1'b0;
      spawn_q    <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      up_cnt_q   <= up_cnt_d;
      up_len_q   <= up_len_d;
      prev_idx_q <= prev_idx_d;
      ledr_q     <= ledr_d;
      mole_idx_q <= mole_idx_d;
      mole_up_q  <= mole_up_d;
      spawn_q    <= spawn_d;
      miss_q     <= miss_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    up_cnt_d   = up_cnt_q;
    up_len_d   = up_len_q;
    prev_idx_d = prev_idx_q;
    ledr_d     = ledr_q;
    mole_idx_d = mole_idx_q;
    mole_up_d  = mole_up_q;
    spawn_d    = 1'b0;
    miss_d     = 1'b0;
    new_idx    = reduce_idx(lfsr_q[4:0], prev_idx_q, N_LEDS);

    // Dropping enable aborts silently from any state
    if (!enable) begin
      state_d   = IDLE;
      ledr_d    = '0;
      mole_up_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = GAP;
          gap_cnt_d = GAP_LAST;
          up_len_d  = UP_INIT;
        end
        GAP: begin
          if (gap_cnt_q == '0) begin
            state_d    = UP;
            ledr_d     = N_LEDS'(1) << new_idx;
            mole_idx_d = new_idx;
            prev_idx_d = new_idx;
            mole_up_d  = 1'b1;
            spawn_d    = 1'b1;
            up_cnt_d   = up_len_q - ONE;
          end else begin
            gap_cnt_d = gap_cnt_q - ONE;
          end
        end
        UP: begin
          if (hit) begin
            state_d   = GAP;
            ledr_d    = '0;
            mole_up_d = 1'b0;
            gap_cnt_d = GAP_LAST;
            up_len_d  = shrunk_len;
          end else if (up_cnt_q == '0) begin
            state_d   = GAP;
            ledr_d    = '0;
            mole_up_d = 1'b0;
            gap_cnt_d = GAP_LAST;
            miss_d    = 1'b1;
          end else begin
            up_cnt_d = up_cnt_q - ONE;
          end
        end
        default: begin
          state_d   = IDLE;
          ledr_d    = '0;
          mole_up_d = 1'b0;
        end
      endcase
    end
  end

  assign ledr     = ledr_q;
  assign mole_idx = mole_idx_q;
  assign mole_up  = mole_up_q;
  assign spawn    = spawn_q;
  assign miss     = miss_q;

endmodule
